// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side drain stage for a first-word-fall-through async FIFO. It runs
//   in the FIFO read-clock domain. Words are popped from the FIFO and
//   presented on a registered valid/ready stream through a 2-entry buffer
//   (head + skid). Every BURST_LEN-th delivered word is tagged with m_last,
//   and a free-running counter tracks how many words the sink has accepted.
//
// Parameters
//   DSIZE     data width (matches the FIFO)
//   BURST_LEN words per burst, 1..256
//   CW        width of the delivered-word counter
//
// Ports
//   rclk      in   read clock
//   rrst_n    in   asynchronous active-low reset
//   en        in   drain enable; gates new pops only
//   rinc      out  FIFO pop strobe
//   rdata     in   FIFO head word (valid while rempty=0)
//   rempty    in   FIFO empty flag
//   arempty   in   FIFO almost-empty flag (feeds low_water only)
//   m_valid   out  stream word valid
//   m_ready   in   sink accepts the word
//   m_data    out  stream word
//   m_last    out  last word of a burst
//   low_water out  registered copy of arempty
//   words_out out  count of accepted stream words, wraps modulo 2^CW
module fifo_rd_stream #(
  parameter int DSIZE     = 32,
  parameter int BURST_LEN = 4,
  parameter int CW        = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  input  logic             arempty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic             low_water,
  output logic [CW-1:0]    words_out
);

  // A 1-bit beat counter is kept even for BURST_LEN=1; it simply stays 0.
  localparam int            BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

  logic             run_reg;
  logic [1:0]       occ_reg,   occ_next;
  logic [DSIZE-1:0] head_reg,  head_next;
  logic [DSIZE-1:0] skid_reg,  skid_next;
  logic [BW-1:0]    beat_reg,  beat_next;
  logic [CW-1:0]    words_reg, words_next;
  logic             low_water_reg;

  logic accept;
  logic push;

  // Pop only from registered state and FIFO flags: the sink's m_ready never
  // reaches rinc combinationally, which is why a 2-entry buffer is needed to
  // keep full throughput under backpressure.
  assign push   = run_reg & en & ~rempty & (occ_reg != 2'd2);
  assign accept = (occ_reg != 2'd0) & m_ready;

  assign rinc      = push;
  assign m_valid   = (occ_reg != 2'd0);
  assign m_data    = head_reg;
  assign m_last    = (occ_reg != 2'd0) & (beat_reg == BEAT_MAX);
  assign low_water = low_water_reg;
  assign words_out = words_reg;

  always_comb begin
    occ_next   = occ_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    beat_next  = beat_reg;
    words_next = words_reg;

    case ({push, accept})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase

    // Draining a full buffer promotes the skid word to the head.
    if (accept && (occ_reg == 2'd2)) begin
      head_next = skid_reg;
    end

    // The incoming word lands in the head when the head is free after this
    // edge (buffer empty, or single word leaving now); otherwise it queues
    // behind the head in the skid register. push implies occ<2, so it never
    // collides with the skid promotion above.
    if (push) begin
      if ((occ_reg == 2'd0) || ((occ_reg == 2'd1) && accept)) begin
        head_next = rdata;
      end else begin
        skid_next = rdata;
      end
    end

    if (accept) begin
      beat_next  = (beat_reg == BEAT_MAX) ? '0 : beat_reg + BW'(1);
      words_next = words_reg + CW'(1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run_reg       <= 1'b0;
      occ_reg       <= 2'd0;
      head_reg      <= '0;
      skid_reg      <= '0;
      beat_reg      <= '0;
      words_reg     <= '0;
      low_water_reg <= 1'b1;
    end else begin
      // Holds pops off for the first edge after reset release so the FIFO,
      // reset in the same event, has settled its flags.
      run_reg       <= 1'b1;
      occ_reg       <= occ_next;
      head_reg      <= head_next;
      skid_reg      <= skid_next;
      beat_reg      <= beat_next;
      words_reg     <= words_next;
      low_water_reg <= arempty;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a FWFT FIFO model feeds the DUT; every word
// loaded is pushed into an expected queue with its hand-derived m_last; a
// negedge monitor pops and compares on each accepted stream word.
module tb_fifo_rd_stream;

  localparam int DSIZE     = 32;
  localparam int BURST_LEN = 4;
  localparam int CW        = 4;

  logic             clk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             en = 1'b1;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             arempty = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [DSIZE-1:0] m_data;
  logic             m_last;
  logic             low_water;
  logic [CW-1:0]    words_out;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DSIZE(DSIZE), .BURST_LEN(BURST_LEN), .CW(CW)
  ) dut (
    .rclk(clk), .rrst_n(rrst_n), .en(en), .rinc(rinc),
    .rdata(rdata), .rempty(rempty), .arempty(arempty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .low_water(low_water), .words_out(words_out)
  );

  // ---------------- FWFT FIFO model ----------------
  logic [31:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        rinc_s = 1'b0;

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr];

  always @(posedge clk) begin
    if (rinc_s) rd_ptr <= rd_ptr + 8'd1;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   k = 0;          // words loaded since reset (burst position)
  int   acc_total = 0;
  int   rinc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic load(input logic [31:0] d);
    exp_t e;
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    e.d = d;
    e.l = ((k % BURST_LEN) == BURST_LEN - 1);
    exp_q.push_back(e);
    k++;
  endtask

  // ---------------- monitor ----------------
  logic [CW-1:0] mon_cnt = '0;
  logic [CW-1:0] prev_wo = '0;
  logic          saw_wrap = 1'b0;
  logic          hold = 1'b0;
  logic [31:0]   hold_d = '0;
  logic          hold_l = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    rinc_s = rinc;
    if (!rrst_n) begin
      mon_cnt = '0;
      prev_wo = '0;
      hold    = 1'b0;
    end else begin
      if (rinc) rinc_cnt++;
      check("words_out", 32'(words_out), 32'(mon_cnt));
      if (prev_wo == 4'd15 && words_out == 4'd0) saw_wrap = 1'b1;
      prev_wo = words_out;
      if (hold) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", m_data, hold_d);
        check("hold_last", 32'(m_last), 32'(hold_l));
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h, required no word", m_data);
        end else if (m_ready) begin
          e = exp_q.pop_front();
          check("data", m_data, e.d);
          check("last", 32'(m_last), 32'(e.l));
          $display("accept #%0d data=%h last=%0b", acc_total, m_data, m_last);
          mon_cnt++;
          acc_total++;
        end
      end
      hold   = m_valid & ~m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exp_q.size() == 0 && !m_valid) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout, %0d words still expected", name, exp_q.size());
  endtask

  initial begin
    int base_acc;
    int base_rinc;
    bit got;

    // Reset values with a non-empty FIFO and en=1.
    for (int i = 1; i <= 8; i++) load(32'(i));
    tick();
    tick();
    check("rst_rinc", 32'(rinc), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_words", 32'(words_out), 32'd0);
    check("rst_low_water", 32'(low_water), 32'd1);
    rrst_n = 1'b1;
    #1 check("rinc_at_release", 32'(rinc), 32'd0);
    tick();
    check("rinc_after_run", 32'(rinc), 32'd1);
    check("low_water_follow", 32'(low_water), 32'd0);

    // Streaming: one word per cycle, no gaps.
    tick();
    for (int i = 0; i < 8; i++) begin
      check("stream_gapless", 32'(m_valid), 32'd1);
      tick();
    end
    check("stream_idle", 32'(m_valid), 32'd0);
    check("stream_words", 32'(words_out), 32'd8);

    // Backpressure: exactly two pops fill the buffer, head holds 0x1.
    m_ready   = 1'b0;
    base_rinc = rinc_cnt;
    for (int i = 1; i <= 8; i++) load(32'(i));
    repeat (5) tick();
    check("bp_pops", 32'(rinc_cnt - base_rinc), 32'd2);
    check("bp_rinc_off", 32'(rinc), 32'd0);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_head", m_data, 32'h1);
    m_ready = 1'b1;
    #1 check("bp_rinc_still_off", 32'(rinc), 32'd0);
    tick();
    check("bp_rinc_resume", 32'(rinc), 32'd1);
    wait_drain("bp_drain");

    // Enable dropped after two accepts: buffered word drains, no pops.
    base_acc = acc_total;
    for (int i = 0; i < 4; i++) load(32'h21 + 32'(i));
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (acc_total >= base_acc + 2) got = 1'b1;
    end
    check("en_reach_two", 32'(got), 32'd1);
    en        = 1'b0;
    base_rinc = rinc_cnt;
    repeat (4) tick();
    check("en_no_pop", 32'(rinc_cnt - base_rinc), 32'd0);
    check("en_drained", 32'(acc_total - base_acc), 32'd3);
    check("en_valid_off", 32'(m_valid), 32'd0);
    en = 1'b1;
    wait_drain("en_drain");
    check("en_words", 32'(words_out), 32'd4);

    // Counter wrap with CW=4: 4 + 17 words passes 15 -> 0.
    for (int i = 0; i < 17; i++) load(32'h100 + 32'(i));
    wait_drain("wrap_drain");
    check("wrap_seen", 32'(saw_wrap), 32'd1);
    check("wrap_words", 32'(words_out), 32'd5);

    // low_water tracks arempty one edge later.
    arempty = 1'b1;
    tick();
    check("low_water_set", 32'(low_water), 32'd1);
    arempty = 1'b0;
    tick();
    check("low_water_clr", 32'(low_water), 32'd0);

    // Reset mid-operation with occ=2 and words_out=5.
    m_ready   = 1'b0;
    base_rinc = rinc_cnt;
    for (int i = 0; i < 3; i++) load(32'h41 + 32'(i));
    repeat (4) tick();
    check("mid_pops", 32'(rinc_cnt - base_rinc), 32'd2);
    check("mid_head", m_data, 32'h41);
    check("mid_words", 32'(words_out), 32'd5);
    rrst_n = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_last", 32'(m_last), 32'd0);
    check("arst_rinc", 32'(rinc), 32'd0);
    check("arst_data", m_data, 32'd0);
    check("arst_words", 32'(words_out), 32'd0);
    check("arst_low_water", 32'(low_water), 32'd1);
    // FIFO is reset in the same event: drop its contents and expectations.
    wr_ptr = rd_ptr;
    exp_q.delete();
    k = 0;
    tick();
    for (int i = 0; i < 4; i++) load(32'h51 + 32'(i));
    m_ready = 1'b1;
    tick();
    rrst_n = 1'b1;
    wait_drain("post_rst_drain");
    check("post_rst_words", 32'(words_out), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
